iob_irq_ctrl: RTL

Parametrised platform-level interrupt controller with an IOb native slave port, generalising the fixed 8-source/2-target PLIC in source count, target count, priority width and per-source trigger mode. Each source passes through a gateway (level or counted-edge), is arbitrated per target by priority and threshold, and is served through claim/complete registers. It sits on the peripheral bus and drives the machine external interrupt line of each hart.

---
 rtl/iob_irq_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/iob_irq_ctrl.sv
// Parametrised platform-level interrupt controller on an IOb slave port.
// Optional `IOB_IRQ_CTRL_SYNC_EN adds a 2-flop synchroniser on src before the gateways.
module iob_irq_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int SOURCES     = 8,
  parameter int TARGETS     = 2,
  parameter int PRIO_W      = 3,
  parameter int MAX_PENDING = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic                  iob_avalid,
  input  logic [ADDR_W-1:0]     iob_addr,
  input  logic [DATA_W-1:0]     iob_wdata,
  input  logic [DATA_W/8-1:0]   iob_wstrb,
  output logic                  iob_rvalid,
  output logic [DATA_W-1:0]     iob_rdata,
  output logic                  iob_ready,
  input  logic [SOURCES-1:0]    src,
  output logic [TARGETS-1:0]    irq
);

  localparam int ID_W  = $clog2(SOURCES + 1);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic [SOURCES:1] src_s;

`ifdef IOB_IRQ_CTRL_SYNC_EN
  logic [SOURCES:1] sync_q1, sync_q2;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else if (cke_i) begin
      sync_q1 <= src;
      sync_q2 <= sync_q1;
    end
  end

  assign src_s = sync_q2;
`else
  assign src_s = src;
`endif

  // Source-indexed vectors keep bit 0 permanently zero so ID 0 means "none".
  logic [PRIO_W-1:0] prio_q [1:SOURCES];
  logic [CNT_W-1:0]  cnt_q  [1:SOURCES];
  logic [CNT_W-1:0]  cnt_d  [1:SOURCES];
  logic [SOURCES:0]  edge_q, pend_q, pend_d, infl_q, infl_d;
  logic [SOURCES:1]  src_prev_q;
  logic [SOURCES:0]  en_q        [TARGETS];
  logic [PRIO_W-1:0] thr_q       [TARGETS];
  logic [ID_W-1:0]   best_id_q   [TARGETS];
  logic [PRIO_W-1:0] best_prio_q [TARGETS];
  logic [ID_W-1:0]   best_id_d   [TARGETS];
  logic [PRIO_W-1:0] best_prio_d [TARGETS];

  logic              wr_en, rd_en, in_map, claim_hit, claim_go, compl_go;
  logic [7:0]        word;
  logic [ID_W-1:0]   cid;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_addr;

  assign iob_ready   = 1'b1;
  assign wr_en       = iob_avalid && (iob_wstrb == '1);
  assign rd_en       = iob_avalid && (iob_wstrb == '0);
  assign word        = iob_addr[9:2];
  assign in_map      = (iob_addr >> 10) == '0;
  assign unused_addr = ^iob_addr[1:0];
  assign claim_go    = rd_en && claim_hit;
  assign compl_go    = wr_en && claim_hit;

  // Register read mux and claim decode. A stale best_id whose source is no
  // longer pending (e.g. claimed the cycle before) is reported as 0.
  always_comb begin
    rd_mux    = '0;
    claim_hit = 1'b0;
    cid       = '0;
    if (in_map) begin
      for (int s = 1; s <= SOURCES; s++)
        if (word == 8'(s)) rd_mux[PRIO_W-1:0] = prio_q[s];
      if (word == 8'd32) rd_mux[SOURCES:0] = pend_q;
      if (word == 8'd33) rd_mux[SOURCES:0] = edge_q;
      for (int t = 0; t < TARGETS; t++) begin
        if (word == 8'(64 + t))      rd_mux[SOURCES:0]  = en_q[t];
        if (word == 8'(128 + 2 * t)) rd_mux[PRIO_W-1:0] = thr_q[t];
        if (word == 8'(129 + 2 * t)) begin
          claim_hit        = 1'b1;
          cid              = pend_q[best_id_q[t]] ? best_id_q[t] : '0;
          rd_mux[ID_W-1:0] = cid;
        end
      end
    end
  end

  // Gateways: in-flight tracking, edge counters and next pending state.
  always_comb begin
    infl_d = infl_q;
    pend_d = '0;
    cnt_d  = cnt_q;
    for (int s = 1; s <= SOURCES; s++) begin
      logic claim_s, compl_s, rise;
      claim_s   = claim_go && (cid == ID_W'(s));
      compl_s   = compl_go && (iob_wdata == DATA_W'(s)) && infl_q[s];
      rise      = src_s[s] && !src_prev_q[s];
      infl_d[s] = (infl_q[s] && !compl_s) || claim_s;
      if (!edge_q[s])
        cnt_d[s] = '0;
      else if (rise && !claim_s)
        cnt_d[s] = (cnt_q[s] == CNT_W'(MAX_PENDING)) ? cnt_q[s] : cnt_q[s] + CNT_W'(1);
      else if (!rise && claim_s && cnt_q[s] != '0)
        cnt_d[s] = cnt_q[s] - CNT_W'(1);
      else
        cnt_d[s] = cnt_q[s];
      pend_d[s] = (edge_q[s] ? (cnt_d[s] != '0) : src_s[s]) && !infl_d[s];
    end
    infl_d[0] = 1'b0;
  end

  // Per-target arbitration; strict compare in ascending ID order breaks ties low.
  always_comb begin
    for (int t = 0; t < TARGETS; t++) begin
      best_id_d[t]   = '0;
      best_prio_d[t] = '0;
      for (int s = 1; s <= SOURCES; s++) begin
        if (pend_q[s] && en_q[t][s] && prio_q[s] > best_prio_d[t]) begin
          best_prio_d[t] = prio_q[s];
          best_id_d[t]   = ID_W'(s);
        end
      end
    end
  end

  always_comb begin
    irq = '0;
    for (int t = 0; t < TARGETS; t++) irq[t] = best_prio_q[t] > thr_q[t];
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      edge_q     <= '0;
      pend_q     <= '0;
      infl_q     <= '0;
      src_prev_q <= '0;
      iob_rvalid <= 1'b0;
      iob_rdata  <= '0;
      for (int s = 1; s <= SOURCES; s++) begin
        prio_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
      for (int t = 0; t < TARGETS; t++) begin
        en_q[t]        <= '0;
        thr_q[t]       <= '0;
        best_id_q[t]   <= '0;
        best_prio_q[t] <= '0;
      end
    end else if (cke_i) begin
      pend_q     <= pend_d;
      infl_q     <= infl_d;
      src_prev_q <= src_s;
      iob_rvalid <= rd_en;
      if (rd_en) iob_rdata <= rd_mux;
      for (int s = 1; s <= SOURCES; s++) cnt_q[s] <= cnt_d[s];
      for (int t = 0; t < TARGETS; t++) begin
        best_id_q[t]   <= best_id_d[t];
        best_prio_q[t] <= best_prio_d[t];
      end
      if (wr_en && in_map) begin
        for (int s = 1; s <= SOURCES; s++)
          if (word == 8'(s)) prio_q[s] <= iob_wdata[PRIO_W-1:0];
        if (word == 8'd33) edge_q <= {iob_wdata[SOURCES:1], 1'b0};
        for (int t = 0; t < TARGETS; t++) begin
          if (word == 8'(64 + t))      en_q[t]  <= {iob_wdata[SOURCES:1], 1'b0};
          if (word == 8'(128 + 2 * t)) thr_q[t] <= iob_wdata[PRIO_W-1:0];
        end
      end
    end
  end

endmodule
